edge_detector: RTL and testbench
================================

Name: edge_detector

Overview:
- Per-bit rising- and falling-edge detector for level signals in the single clock domain.
- For each input bit, emits a one-cycle pulse on the cycle the sampled level changes 0->1 (rising) or 1->0 (falling).
- Optional input synchronizer stages allow use on asynchronous sources.
- Optional output register gives glitch-free, fully registered pulses.
- Used as a generic utility wherever control logic needs change events instead of levels.

Parameters:
- WIDTH, 1, number of independent input bits monitored; legal range 1..64.
- SYNC_STAGES, 0, number of flip-flop synchronizer stages in front of the detector; 0 (input already synchronous) or 2..4. A value of 1 is illegal and must be flagged by an elaboration-time assertion.
- REGISTERED_OUT, 0, 0 = pulses decoded combinationally from the current and previous sample; 1 = pulses registered, adding one cycle of latency.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset; clears all internal state and outputs.
- a_i, input, WIDTH, monitored level signal(s).
- rising_edge_o, output, WIDTH, bit n pulses high for one cycle on a 0->1 transition of bit n.
- falling_edge_o, output, WIDTH, bit n pulses high for one cycle on a 1->0 transition of bit n.

Behaviour:
- Reset: asserting reset immediately (asynchronously) clears all synchronizer flops, the previous-sample register and the output registers to 0.
- While reset is high, rising_edge_o = 0 and falling_edge_o = 0. This holds even in combinational mode, where the outputs are masked by reset.
- Define s = a_i after SYNC_STAGES flops; s = a_i when SYNC_STAGES = 0.
- Each rising clk edge: prev <= s.
- Combinational decode, per bit: rise = s & ~prev; fall = ~s & prev.
- REGISTERED_OUT = 0: rising_edge_o = rise and falling_edge_o = fall, combinationally. A change of a_i between clock edges appears on the outputs in the same cycle and clears at the next clock edge.
- REGISTERED_OUT = 1: outputs are flops loaded with rise/fall on each clock edge; pulses appear one cycle after the corresponding edge seen in combinational mode.
- Latency in clock edges from an a_i change to the pulse = SYNC_STAGES + REGISTERED_OUT, with 0 meaning same cycle.
- Pulse width is exactly one clk cycle per transition. A steady input (high or low) produces no pulses.
- Toggling every cycle: alternating rise/fall pulses every cycle, never both in the same cycle for the same bit.
- Mutual exclusion: rising_edge_o[n] & falling_edge_o[n] is never 1.
- Bits are fully independent; simultaneous edges on different bits pulse simultaneously.
- Post-reset: prev = 0. If the synchronized input is already 1 at the first clock after reset release, one rising pulse is generated; no falling pulse is possible from reset.
- Reset mid-operation: any in-flight pulse is killed immediately, and detection restarts from prev = 0.
- Glitches shorter than a clock period that do not straddle a rising clk edge are not detected in REGISTERED_OUT = 1 mode. In REGISTERED_OUT = 0 mode they may appear on the combinational outputs; consumers must sample synchronously.

Test Plan:
- Reset hold: reset = 1 for 2 cycles with a_i toggling -> both outputs 0 throughout. Release reset with a_i = 0 -> no pulses.
- Single rising edge (WIDTH = 1, defaults): a_i 0->1 one time unit after a clk edge, then held high -> rising_edge_o = 1 until the next clk edge, then 0. falling_edge_o stays 0.
- Single falling edge: a_i 1->0 after a settled high -> falling_edge_o is a one-cycle pulse and rising_edge_o stays 0. Holding a_i low for 5 cycles produces no further pulses.
- Random stimulus: 10 cycles of random a_i, changed one time unit after each clk edge -> every cycle, rise == (a_i & ~prev) and fall == (~a_i & prev), rise & fall == 0, and the pulse count equals the transition count.
- Latency and width variants: WIDTH = 4, SYNC_STAGES = 2, REGISTERED_OUT = 1; a_i = 4'b0000 -> 4'b0101 -> rising_edge_o = 4'b0101 exactly 3 clk edges later, for one cycle.
- Asynchronous reset mid-pulse: assert reset while rising_edge_o = 1 -> output drops to 0 without waiting for clk. After release with a_i = 1 -> one rising pulse.

Source files
------------

// File: rtl/edge_detector.sv
// Per-bit rising/falling edge detector with optional input synchronizer
// and optional registered outputs. Reset is asynchronous and active-high.
module edge_detector #(
   parameter int WIDTH          = 1,
   parameter int SYNC_STAGES    = 0,
   parameter int REGISTERED_OUT = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a_i,
   output logic [WIDTH-1:0] rising_edge_o,
   output logic [WIDTH-1:0] falling_edge_o
);

   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] prev_reg;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   generate
      if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
         $error("edge_detector: WIDTH must be in 1..64");
      end
      // A single synchronizer flop gives no metastability protection, so reject it.
      if (SYNC_STAGES == 1 || SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
         $error("edge_detector: SYNC_STAGES must be 0 or 2..4");
      end
      if (REGISTERED_OUT != 0 && REGISTERED_OUT != 1) begin : g_bad_reg
         $error("edge_detector: REGISTERED_OUT must be 0 or 1");
      end
   endgenerate

   generate
      if (SYNC_STAGES >= 2) begin : g_sync
         logic [WIDTH-1:0] sync_reg [SYNC_STAGES];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < SYNC_STAGES; i++) begin
                  sync_reg[i] <= '0;
               end
            end else begin
               sync_reg[0] <= a_i;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_reg[i] <= sync_reg[i-1];
               end
            end
         end

         assign s = sync_reg[SYNC_STAGES-1];
      end else begin : g_no_sync
         assign s = a_i;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_reg <= '0;
      end else begin
         prev_reg <= s;
      end
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
         assign rise[gi] = s[gi] & ~prev_reg[gi];
         assign fall[gi] = ~s[gi] & prev_reg[gi];
      end
   endgenerate

   generate
      if (REGISTERED_OUT == 1) begin : g_reg_out
         logic [WIDTH-1:0] rise_reg;
         logic [WIDTH-1:0] fall_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               rise_reg <= '0;
               fall_reg <= '0;
            end else begin
               rise_reg <= rise;
               fall_reg <= fall;
            end
         end

         assign rising_edge_o  = rise_reg;
         assign falling_edge_o = fall_reg;
      end else begin : g_comb_out
         // Mask with reset so a 1 on a_i cannot leak through while prev is held at 0.
         assign rising_edge_o  = rise & {WIDTH{~reset}};
         assign falling_edge_o = fall & {WIDTH{~reset}};
      end
   endgenerate

endmodule

// File: tb/tb_edge_detector.sv
// Scoreboard bench: dut0 uses defaults (combinational), dut1 is WIDTH=4,
// SYNC_STAGES=2, REGISTERED_OUT=1. Expected pulses are hand-computed per cycle.
module tb_edge_detector;

   typedef struct {
      string      tag;
      logic [1:0] exp;
   } e0_t;

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } e1_t;

   logic       clk;
   logic       reset;
   logic       a0;
   logic       rise0;
   logic       fall0;
   logic [3:0] a1;
   logic [3:0] rise1;
   logic [3:0] fall1;

   e0_t q0[$];
   e1_t q1[$];

   int check_count = 0;
   int pass_count  = 0;
   int pulse0_cnt  = 0;
   int base_cnt    = 0;

   edge_detector dut0 (
      .clk            (clk),
      .reset          (reset),
      .a_i            (a0),
      .rising_edge_o  (rise0),
      .falling_edge_o (fall0)
   );

   edge_detector #(
      .WIDTH          (4),
      .SYNC_STAGES    (2),
      .REGISTERED_OUT (1)
   ) dut1 (
      .clk            (clk),
      .reset          (reset),
      .a_i            (a1),
      .rising_edge_o  (rise1),
      .falling_edge_o (fall1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      check_count++;
      if (got === exp) begin
         pass_count++;
         $display("ok   %s got %b", tag, got);
      end else begin
         $display("FAIL %s got %b expected %b", tag, got, exp);
      end
   endtask

   // Monitor: every negedge, pop whatever the stimulus queued for this cycle.
   always @(negedge clk) begin
      pulse0_cnt = pulse0_cnt + int'(rise0) + int'(fall0);
      if (q0.size() > 0) begin
         e0_t e;
         e = q0.pop_front();
         check({"dut0 ", e.tag}, {6'b0, rise0, fall0}, {6'b0, e.exp});
      end
      if (q1.size() > 0) begin
         e1_t e;
         e = q1.pop_front();
         check({"dut1 ", e.tag}, {rise1, fall1}, e.exp);
      end
   end

   // One clock cycle: drive inputs 1 time unit after the edge, queue expectations.
   task automatic step(input logic rstv, input logic a0v, input logic [1:0] e0, input bit use0,
                       input logic [3:0] a1v, input logic [7:0] e1, input bit use1,
                       input string tag);
      @(posedge clk);
      #1;
      reset = rstv;
      a0    = a0v;
      a1    = a1v;
      if (use0) q0.push_back('{tag: tag, exp: e0});
      if (use1) q1.push_back('{tag: tag, exp: e1});
   endtask

   logic       rnd_a [10];
   logic [1:0] rnd_e [10];

   initial begin
      reset = 1'b1;
      a0    = 1'b0;
      a1    = 4'h0;

      // Reset hold with toggling inputs
      step(1, 1, 2'b00, 1, 4'hf, 8'h00, 1, "reset_hold0");
      step(1, 0, 2'b00, 1, 4'h0, 8'h00, 1, "reset_hold1");
      step(0, 0, 2'b00, 1, 4'h0, 8'h00, 1, "release_low");
      step(0, 0, 2'b00, 1, 4'h0, 8'h00, 1, "idle_low");

      // Single rising edge then held high
      step(0, 1, 2'b10, 1, 4'h0, 8'h00, 0, "single_rise");
      step(0, 1, 2'b00, 1, 4'h0, 8'h00, 0, "rise_cleared");
      step(0, 1, 2'b00, 1, 4'h0, 8'h00, 0, "steady_high");

      // Single falling edge then held low for 5 cycles
      step(0, 0, 2'b01, 1, 4'h0, 8'h00, 0, "single_fall");
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 2'b00, 1, 4'h0, 8'h00, 0, "steady_low");
      end

      // Fixed pseudo-random sequence, expected {rise,fall} worked out by hand from prev=0
      rnd_a = '{1, 1, 0, 1, 0, 0, 1, 1, 1, 0};
      rnd_e = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
      @(negedge clk);
      #1;
      base_cnt = pulse0_cnt;
      for (int i = 0; i < 10; i++) begin
         step(0, rnd_a[i], rnd_e[i], 1, 4'h0, 8'h00, 0, $sformatf("rand%0d", i));
      end
      @(negedge clk);
      #1;
      check("dut0 pulse_count", 8'(pulse0_cnt - base_cnt), 8'd6);

      // dut1: latency of 3 edges, independent bits
      step(0, 0, 2'b00, 0, 4'b0000, 8'h00, 1, "lat_s0");
      step(0, 0, 2'b00, 0, 4'b0101, 8'h00, 1, "lat_s1");
      step(0, 0, 2'b00, 0, 4'b0101, 8'h00, 1, "lat_s2");
      step(0, 0, 2'b00, 0, 4'b0101, 8'h00, 1, "lat_s3");
      step(0, 0, 2'b00, 0, 4'b1100, {4'b0101, 4'b0000}, 1, "lat_rise_0101");
      step(0, 0, 2'b00, 0, 4'b1100, 8'h00, 1, "lat_s5");
      step(0, 0, 2'b00, 0, 4'b1100, 8'h00, 1, "lat_s6");
      step(0, 0, 2'b00, 0, 4'b1100, {4'b1000, 4'b0001}, 1, "lat_mixed");
      step(0, 0, 2'b00, 0, 4'b1100, 8'h00, 1, "lat_s8");
      step(0, 0, 2'b00, 0, 4'b1100, 8'h00, 1, "lat_s9");

      // Asynchronous reset while both DUTs are mid-pulse
      step(0, 0, 2'b00, 0, 4'b1111, 8'h00, 0, "arm");
      step(0, 0, 2'b00, 0, 4'b1111, 8'h00, 0, "arm");
      step(0, 0, 2'b00, 0, 4'b1111, 8'h00, 0, "arm");
      step(0, 1, 2'b00, 0, 4'b1111, 8'h00, 0, "arm");
      #1;
      check("dut0 pre_reset_pulse", {6'b0, rise0, fall0}, 8'b0000_0010);
      check("dut1 pre_reset_pulse", {rise1, fall1}, {4'b0011, 4'b0000});
      #1;
      reset = 1'b1;
      #1;
      check("dut0 async_kill", {6'b0, rise0, fall0}, 8'h00);
      check("dut1 async_kill", {rise1, fall1}, 8'h00);

      step(0, 1, 2'b10, 1, 4'b1111, 8'h00, 1, "post_reset_r0");
      step(0, 1, 2'b00, 1, 4'b1111, 8'h00, 1, "post_reset_r1");
      step(0, 1, 2'b00, 1, 4'b1111, 8'h00, 1, "post_reset_r2");
      step(0, 1, 2'b00, 1, 4'b1111, {4'b1111, 4'b0000}, 1, "post_reset_r3");
      step(0, 1, 2'b00, 1, 4'b1111, 8'h00, 1, "post_reset_r4");

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
